// File: rtl/instruction_fetch_unit.sv
// Fetches in program order through a direct-mapped, one-word-per-line I-cache; misses go to the memory controller.
// Hit: 1 cycle, 1/cycle; miss: controller latency + 2. dsp_full_in stalls hits only; a miss still requests.
module instruction_fetch_unit #(
    parameter int          ICACHE_INDEX_BITS = 8,
    parameter logic [31:0] RESET_PC          = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rob_rollback_in,
    input  logic [31:0] rob_target_pc_in,
    input  logic        mem_ready_in,
    input  logic [31:0] mem_instruction_in,
    output logic        mem_request_out,
    output logic [31:0] mem_address_out,
    input  logic        dsp_full_in,
    output logic        dsp_valid_out,
    output logic [31:0] dsp_instruction_out,
    output logic [31:0] dsp_pc_out
);

    localparam int LINES    = 1 << ICACHE_INDEX_BITS;
    localparam int TAG_BITS = 30 - ICACHE_INDEX_BITS;

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t                       state, state_nxt;
    logic [31:0]                  pc, pc_nxt;
    logic [LINES-1:0]             line_vld;
    logic [TAG_BITS-1:0]          tag_mem  [LINES];
    logic [31:0]                  data_mem [LINES];
    logic [ICACHE_INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]          tag;
    logic                         hit;
    logic                         emit;
    logic                         issue_req;
    logic                         fill;
    logic                         unused_target_low;

    assign index = pc[ICACHE_INDEX_BITS+1:2];
    assign tag   = pc[31:ICACHE_INDEX_BITS+2];
    assign hit   = line_vld[index] && (tag_mem[index] == tag);

    // Targets are word aligned; the low bits carry no information.
    assign unused_target_low = ^rob_target_pc_in[1:0];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        emit      = 1'b0;
        issue_req = 1'b0;
        fill      = 1'b0;
        if (rob_rollback_in) begin
            // Drops any outstanding miss; a fill returning this cycle is discarded.
            state_nxt = IDLE;
            pc_nxt    = {rob_target_pc_in[31:2], 2'b00};
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (!dsp_full_in) begin
                            emit   = 1'b1;
                            pc_nxt = pc + 32'd4;
                        end
                    end else begin
                        issue_req = 1'b1;
                        state_nxt = WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (mem_ready_in) begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            pc                  <= {RESET_PC[31:2], 2'b00};
            line_vld            <= '0;
            mem_request_out     <= 1'b0;
            mem_address_out     <= '0;
            dsp_valid_out       <= 1'b0;
            dsp_instruction_out <= '0;
            dsp_pc_out          <= '0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            mem_request_out <= issue_req;
            dsp_valid_out   <= emit;
            if (issue_req) begin
                mem_address_out <= pc;
            end
            if (emit) begin
                dsp_instruction_out <= data_mem[index];
                dsp_pc_out          <= pc;
            end
            if (fill) begin
                line_vld[index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid vector alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= mem_instruction_in;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench: memory-controller responder plus program-order scoreboard and a line-set model of the cache.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rob_rollback_in;
    logic [31:0] rob_target_pc_in;
    logic        mem_ready_in;
    logic [31:0] mem_instruction_in;
    logic        mem_request_out;
    logic [31:0] mem_address_out;
    logic        dsp_full_in;
    logic        dsp_valid_out;
    logic [31:0] dsp_instruction_out;
    logic [31:0] dsp_pc_out;

    instruction_fetch_unit #(
        .ICACHE_INDEX_BITS(8),
        .RESET_PC         (32'h0000_0000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rob_rollback_in    (rob_rollback_in),
        .rob_target_pc_in   (rob_target_pc_in),
        .mem_ready_in       (mem_ready_in),
        .mem_instruction_in (mem_instruction_in),
        .mem_request_out    (mem_request_out),
        .mem_address_out    (mem_address_out),
        .dsp_full_in        (dsp_full_in),
        .dsp_valid_out      (dsp_valid_out),
        .dsp_instruction_out(dsp_instruction_out),
        .dsp_pc_out         (dsp_pc_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] next_push_pc;
    logic [31:0] cache_m [int];
    bit          outst;
    int          lat;
    logic [31:0] outst_addr;
    int          fixed_lat;
    bit          force_rb_rdy;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          val_edges[$];
    int          req_edges[$];
    int          rdy_edges[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ {a[7:0], a[31:8]} ^ 32'h0BAD_F00D;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
        return n;
    endfunction

    function automatic bit model_has(input logic [31:0] a);
        return cache_m.exists(idx(a)) && (cache_m[idx(a)] == a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back({next_push_pc, mem_word(next_push_pc)});
            next_push_pc = next_push_pc + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        next_push_pc = {pc[31:2], 2'b00};
        refill();
    endtask

    // One cycle of stimulus and memory-controller behaviour, applied at the falling edge.
    task automatic step(input bit r, input bit rb, input logic [31:0] tgt, input bit full);
        @(negedge clk);
        rst                = r;
        rob_rollback_in    = rb;
        rob_target_pc_in   = tgt;
        dsp_full_in        = full;
        mem_ready_in       = 1'b0;
        mem_instruction_in = $urandom;
        if (r) begin
            outst = 1'b0;
            cache_m.delete();
            restart_stream(32'h0);
        end else if (rb) begin
            if (outst && (force_rb_rdy || $urandom_range(1, 0) == 1)) begin
                mem_ready_in       = 1'b1;
                mem_instruction_in = mem_word(outst_addr);
            end
            outst = 1'b0;
            restart_stream(tgt);
        end else begin
            if (mem_request_out) begin
                outst      = 1'b1;
                outst_addr = mem_address_out;
                lat        = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
            end
            if (outst) begin
                if (lat == 0) begin
                    mem_ready_in       = 1'b1;
                    mem_instruction_in = mem_word(outst_addr);
                    cache_m[idx(outst_addr)] = outst_addr;
                    outst = 1'b0;
                    rdy_edges.push_back(cyc + 1);
                end else begin
                    lat--;
                end
            end else if ($urandom_range(15, 0) == 0) begin
                mem_ready_in = 1'b1;
            end
            refill();
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] base;
        case ($urandom_range(4, 0))
            0:       base = 32'h0000_0000;
            1:       base = 32'h0000_0400;
            2:       base = 32'h0000_0100;
            3:       base = 32'hFFFF_FFF0;
            default: base = 32'h0000_0800;
        endcase
        return base + 32'($urandom_range(15, 0) * 4) + 32'($urandom_range(3, 0));
    endfunction

    // Monitor: everything the DUT presents is compared at 1 time unit after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                chk("rst_dsp_valid", {31'b0, dsp_valid_out}, 32'h0);
                chk("rst_dsp_instr", dsp_instruction_out, 32'h0);
                chk("rst_dsp_pc", dsp_pc_out, 32'h0);
                chk("rst_mem_request", {31'b0, mem_request_out}, 32'h0);
                chk("rst_mem_address", mem_address_out, 32'h0);
            end else if (rob_rollback_in) begin
                chk("rb_dsp_valid", {31'b0, dsp_valid_out}, 32'h0);
                chk("rb_mem_request", {31'b0, mem_request_out}, 32'h0);
            end else begin
                if (dsp_valid_out) begin
                    val_edges.push_back(cyc);
                    chk("emit_while_full", {31'b0, dsp_full_in}, 32'h0);
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_nonempty", exp_q.size(), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dsp_pc", dsp_pc_out, e.pc);
                        chk("dsp_instr", dsp_instruction_out, e.instr);
                        chk("emit_of_unfilled_line", {31'b0, model_has(e.pc)}, 32'h1);
                    end
                end
                if (mem_request_out) begin
                    req_edges.push_back(cyc);
                    chk("request_while_outstanding", {31'b0, outst}, 32'h0);
                    if (exp_q.size() > 0) chk("req_addr", mem_address_out, exp_q[0].pc);
                    chk("request_on_cached_line", {31'b0, model_has(mem_address_out)}, 32'h0);
                end else if (outst) begin
                    chk("addr_held", mem_address_out, outst_addr);
                end
            end
        end
    end

    initial begin
        int rel_edge, a, b, c, f, g, h, k, rel2, n0;
        rst = 1'b1; rob_rollback_in = 1'b0; rob_target_pc_in = '0;
        mem_ready_in = 1'b0; mem_instruction_in = '0; dsp_full_in = 1'b0;
        outst = 1'b0; lat = 0; outst_addr = '0; force_rb_rdy = 1'b0;
        fixed_lat = 1;
        restart_stream(32'h0);

        // Cold start: request one edge after release, word emitted one edge after the fill edge.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        rel_edge = cyc + 1;
        for (int i = 0; i < 40 && val_edges.size() < 3; i++) step(0, 0, 0, 0);
        chk("warmup_outputs", val_edges.size(), 32'd3);
        chk("first_req_edge", (req_edges.size() > 0) ? req_edges[0] : -1, rel_edge);
        chk("first_val_edge", (val_edges.size() > 0) ? val_edges[0] : -1,
            (rdy_edges.size() > 0) ? rdy_edges[0] + 1 : -2);

        // Warm lines 0,4,8: back-to-back hits with no request; target low bits ignored.
        step(0, 1, 32'h3, 0);
        a = cyc + 1;
        repeat (4) step(0, 0, 0, 0);
        chk("hit_burst_count", count_in(val_edges, a + 1, a + 3), 32'd3);
        chk("hit_burst_no_req", count_in(req_edges, a + 1, a + 3), 32'd0);

        // Backpressure on a hit holds the PC.
        step(0, 1, 32'h0, 0);
        b = cyc + 1;
        step(0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("stall_first_emit", count_in(val_edges, b + 1, b + 1), 32'd1);
        chk("stall_no_valid", count_in(val_edges, b + 2, b + 4), 32'd0);
        chk("stall_release_emit", count_in(val_edges, b + 5, b + 5), 32'd1);

        // Rollback with a miss outstanding, fill arriving in the rollback cycle.
        fixed_lat = 6;
        step(0, 1, 32'h100, 0);
        c = cyc + 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("miss_0x100_req", count_in(req_edges, c + 1, c + 1), 32'd1);
        force_rb_rdy = 1'b1;
        step(0, 1, 32'h203, 0);
        force_rb_rdy = 1'b0;
        f = cyc + 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("req_after_rollback", count_in(req_edges, f + 1, f + 1), 32'd1);
        step(0, 1, 32'h100, 0);
        g = cyc + 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("cancelled_line_unfilled", count_in(req_edges, g + 1, g + 1), 32'd1);

        // Aliasing: 0x400 evicts 0x000.
        fixed_lat = 1;
        step(0, 1, 32'h400, 0);
        h = cyc + 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("alias_miss_0x400", count_in(req_edges, h + 1, h + 1), 32'd1);
        n0 = val_edges.size();
        for (int i = 0; i < 12 && val_edges.size() == n0; i++) step(0, 0, 0, 0);
        chk("alias_fill_emitted", {31'b0, val_edges.size() > n0}, 32'h1);
        fixed_lat = 6;
        step(0, 1, 32'h0, 0);
        k = cyc + 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("alias_refetch_miss", count_in(req_edges, k + 1, k + 1), 32'd1);

        // Reset while waiting on memory: valid bits cleared, refetch misses.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        rel2 = cyc + 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset_refetch_miss", count_in(req_edges, rel2, rel2), 32'd1);

        // Randomized traffic.
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            bit r, rb;
            r  = ($urandom_range(199, 0) == 0);
            rb = !r && ($urandom_range(19, 0) == 0);
            step(r, rb, pick_target(), $urandom_range(3, 0) == 0);
        end

        n0 = val_edges.size();
        repeat (60) step(0, 0, 0, 0);
        chk("drain_progress", {31'b0, (val_edges.size() - n0) >= 5}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
